demux_stream: RTL and testbench
===============================

DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8: payload bits per beat.
REQ-002 SHALL have parameter CHANNELS, default 4, legal range 2..16: number of output channels.
REQ-003 SHALL derive localparam SEL_W = clog2(CHANNELS): select width.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in_data, input, WIDTH: input payload.
REQ-007 SHALL have port in_sel, input, SEL_W: destination channel index.
REQ-008 SHALL have port in_valid, input, 1: input beat offered.
REQ-009 SHALL have port in_ready, output, 1: input beat accepted when in_valid & in_ready.
REQ-010 SHALL have port out_data, output, CHANNELS*WIDTH: lane k at bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have port out_valid, output, CHANNELS: per-channel beat present.
REQ-012 SHALL have port out_ready, input, CHANNELS: per-channel sink accepts.
REQ-013 SHALL have port err, output, 1: one-cycle pulse on an accepted out-of-range select.

Function
REQ-014 SHALL hold one registered slot (data plus valid) per channel; out_valid[k] is the slot valid bit.
REQ-015 SHALL drive out_data lane k with slot data when out_valid[k]=1 and all-zero otherwise.
REQ-016 SHALL compute in_ready combinationally from in_sel only: 1 when slot[in_sel] is empty or out_ready[in_sel]=1; always 1 when in_sel >= CHANNELS.
REQ-017 SHALL, on input handshake with in_sel < CHANNELS, load in_data into slot[in_sel] and set its valid on the next edge; latency in to out_valid is exactly 1 cycle.
REQ-018 SHALL, on output handshake (out_valid[k] & out_ready[k]) with no load to k, clear slot k valid on the next edge.
REQ-019 SHALL, when slot k is drained and loaded in the same cycle, keep valid=1 and present the new data; sustained throughput SHALL be 1 beat/cycle per channel.
REQ-020 SHALL keep slot data and valid stable while out_valid[k]=1 and out_ready[k]=0.
REQ-021 SHALL NOT stall the input for a full channel other than in_sel; non-selected channels drain independently.
REQ-022 SHALL, on input handshake with in_sel >= CHANNELS (CHANNELS not a power of two), discard the beat, leave all slots unchanged, and assert err for exactly the next cycle.
REQ-023 SHALL keep err at 0 in every cycle without such a discard; back-to-back discards SHALL give err high on consecutive cycles.
REQ-024 SHALL have no combinational path from in_data to any output.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously clear all out_valid, all slot data, err, and counters (if present).
REQ-026 SHALL discard slot contents on reset mid-operation; no beat SHALL be emitted after reset until a new input handshake.
REQ-027 SHALL drive in_ready per REQ-016 during reset (all slots empty, so 1).

Configuration
REQ-028 SHALL, with macro DEMUX_STREAM_CNT_EN defined, add output port cnt, CHANNELS*16 bits, lane k = count of output handshakes on channel k, incrementing on the edge after each handshake, wrapping 16'hFFFF to 0.
REQ-029 SHALL, without DEMUX_STREAM_CNT_EN, omit port cnt and all counter logic; all other behaviour SHALL be identical.

Verification
REQ-030 SHALL check: CHANNELS=4, WIDTH=8, in_sel=2, in_data=8'hA5, single handshake, out_ready=4'b1111 -> out_valid=4'b0100 and lane 2 = 8'hA5 one cycle later, lanes 0/1/3 = 0, out_valid=0 the cycle after.
REQ-031 SHALL check: out_ready[1]=0, two beats 8'h11 then 8'h22 to channel 1 -> first accepted, in_ready=0 for second, lane 1 holds 8'h11; raise out_ready[1] -> 8'h22 appears next cycle with no gap.
REQ-032 SHALL check: channel 0 blocked and full, beats to channels 1,2,3 on consecutive cycles -> all accepted, in_ready=1 each cycle, channel 0 unchanged.
REQ-033 SHALL check: CHANNELS=3, in_sel=3, in_valid=1 -> in_ready=1, err=1 for one cycle, out_valid stays 3'b000.
REQ-034 SHALL check: rst_n driven low between clock edges while slots 0 and 3 are full -> out_valid=0 immediately, no beat emitted after rst_n returns high.
REQ-035 SHALL check with DEMUX_STREAM_CNT_EN: 65537 handshakes on channel 0 -> cnt lane 0 = 1, other lanes 0.

Source files
------------

// File: rtl/demux_stream.sv
// demux_stream: one-in, CHANNELS-out stream demultiplexer with one registered
// slot per channel. Channels are independent: a stalled sink only blocks beats
// addressed to its own channel. An accepted beat whose select is >= CHANNELS
// is dropped and flagged on err for one cycle.
// Optional feature: define DEMUX_STREAM_CNT_EN to add per-channel 16-bit
// output-handshake counters on port cnt.

module demux_stream_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             rdy,
  output logic             vld,
  output logic [WIDTH-1:0] dout
`ifdef DEMUX_STREAM_CNT_EN
  ,
  output logic [15:0]      cnt
`endif
);
  logic [WIDTH-1:0] data;

  // Slot register: a load wins over a drain, so a drain+load in one cycle
  // keeps vld high with the new data and the channel runs at full rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      data <= din;
    end else if (vld && rdy) begin
      vld  <= 1'b0;
    end
  end

  // Lane reads zero whenever the slot is empty.
  assign dout = vld ? data : '0;

`ifdef DEMUX_STREAM_CNT_EN
  // Count output handshakes; natural 16-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= 16'd0;
    else if (vld && rdy) cnt <= cnt + 16'd1;
  end
`endif
endmodule

module demux_stream #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      err
`ifdef DEMUX_STREAM_CNT_EN
  ,
  output logic [CHANNELS*16-1:0]    cnt
`endif
);
  localparam logic [SEL_W:0] CH_N = (SEL_W+1)'(CHANNELS);

  logic                             in_range;
  logic [CHANNELS-1:0]              load;
  logic [CHANNELS-1:0][WIDTH-1:0]   lane_data;
`ifdef DEMUX_STREAM_CNT_EN
  logic [CHANNELS-1:0][15:0]        lane_cnt;
  assign cnt = lane_cnt;
`endif

  assign in_range = ({1'b0, in_sel} < CH_N);

  // Ready depends only on the selected channel; out-of-range selects are
  // always accepted so they can be discarded without stalling the source.
  always_comb begin
    in_ready = 1'b1;
    if (in_range) in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    assign load[k] = in_valid & in_ready & in_range & (in_sel == SEL_W'(k));

    demux_stream_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .din   (in_data),
      .rdy   (out_ready[k]),
      .vld   (out_valid[k]),
      .dout  (lane_data[k])
`ifdef DEMUX_STREAM_CNT_EN
      ,
      .cnt   (lane_cnt[k])
`endif
    );
  end

  assign out_data = lane_data;

  // Registered discard flag: high exactly the cycle after each dropped beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= in_valid & ~in_range;
  end
endmodule

// File: tb/tb_demux_stream.sv
// Directed self-checking bench for demux_stream: a CHANNELS=4 instance for the
// main function and a CHANNELS=3 instance for out-of-range select handling.
module tb_demux_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // 4-channel instance
  logic [7:0]  a_data = '0;
  logic [1:0]  a_sel = '0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [31:0] a_odata;
  logic [3:0]  a_ovalid;
  logic [3:0]  a_ordy = 4'b1111;
  logic        a_err;

  // 3-channel instance
  logic [7:0]  b_data = '0;
  logic [1:0]  b_sel = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [23:0] b_odata;
  logic [2:0]  b_ovalid;
  logic [2:0]  b_ordy = 3'b111;
  logic        b_err;

`ifdef DEMUX_STREAM_CNT_EN
  logic [63:0] a_cnt;
  logic [47:0] b_cnt;
`endif

  demux_stream #(.WIDTH(8), .CHANNELS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel),
    .in_valid(a_valid), .in_ready(a_ready), .out_data(a_odata),
    .out_valid(a_ovalid), .out_ready(a_ordy), .err(a_err)
`ifdef DEMUX_STREAM_CNT_EN
    , .cnt(a_cnt)
`endif
  );

  demux_stream #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel),
    .in_valid(b_valid), .in_ready(b_ready), .out_data(b_odata),
    .out_valid(b_ovalid), .out_ready(b_ordy), .err(b_err)
`ifdef DEMUX_STREAM_CNT_EN
    , .cnt(b_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (a_ovalid !== 4'b0000) begin n_bad++; $display("FAIL rst_ovalid4 got %b exp 0000", a_ovalid); end
    n_cmp++; if (a_odata !== 32'h0) begin n_bad++; $display("FAIL rst_odata4 got %h exp 0", a_odata); end
    n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL rst_err4 got %b exp 0", a_err); end
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready4 got %b exp 1", a_ready); end
    n_cmp++; if (b_ovalid !== 3'b000 || b_err !== 1'b0) begin n_bad++; $display("FAIL rst_dut3 got ovalid=%b err=%b exp 000/0", b_ovalid, b_err); end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    a_ordy = 4'b1111; a_sel = 2'd2; a_data = 8'hA5; a_valid = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got %b exp 1", a_ready); end
    step();
    a_valid = 1'b0;
    n_cmp++; if (a_ovalid !== 4'b0100) begin n_bad++; $display("FAIL single_ovalid got %b exp 0100", a_ovalid); end
    n_cmp++; if (a_odata !== 32'h00A5_0000) begin n_bad++; $display("FAIL single_odata got %h exp 00a50000", a_odata); end
    n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL single_err got %b exp 0", a_err); end
    step();
    n_cmp++; if (a_ovalid !== 4'b0000 || a_odata !== 32'h0) begin n_bad++; $display("FAIL single_drain got ovalid=%b odata=%h exp 0000/0", a_ovalid, a_odata); end
  endtask

  task automatic test_backpressure();
    a_ordy = 4'b1101; a_sel = 2'd1; a_data = 8'h11; a_valid = 1'b1;
    step();
    a_data = 8'h22;
    #1;
    n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low got %b exp 0", a_ready); end
    n_cmp++; if (a_odata[15:8] !== 8'h11 || a_ovalid !== 4'b0010) begin n_bad++; $display("FAIL bp_hold1 got lane1=%h ovalid=%b exp 11/0010", a_odata[15:8], a_ovalid); end
    step();
    n_cmp++; if (a_odata[15:8] !== 8'h11 || a_ovalid !== 4'b0010) begin n_bad++; $display("FAIL bp_hold2 got lane1=%h ovalid=%b exp 11/0010", a_odata[15:8], a_ovalid); end
    a_ordy = 4'b1111;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_high got %b exp 1", a_ready); end
    step();
    a_valid = 1'b0;
    n_cmp++; if (a_odata !== 32'h0000_2200 || a_ovalid !== 4'b0010) begin n_bad++; $display("FAIL bp_nogap got odata=%h ovalid=%b exp 00002200/0010", a_odata, a_ovalid); end
    step();
    n_cmp++; if (a_ovalid !== 4'b0000) begin n_bad++; $display("FAIL bp_empty got %b exp 0000", a_ovalid); end
  endtask

  task automatic test_independent();
    a_ordy = 4'b1110; a_sel = 2'd0; a_data = 8'h5A; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    #1;
    n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL ind_ch0_blocked got %b exp 0", a_ready); end
    a_valid = 1'b1; a_sel = 2'd1; a_data = 8'h01;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL ind_ready1 got %b exp 1", a_ready); end
    step();
    n_cmp++; if (a_ovalid !== 4'b0011 || a_odata !== 32'h0000_015A) begin n_bad++; $display("FAIL ind_after1 got ovalid=%b odata=%h exp 0011/0000015a", a_ovalid, a_odata); end
    a_sel = 2'd2; a_data = 8'h02;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL ind_ready2 got %b exp 1", a_ready); end
    step();
    n_cmp++; if (a_ovalid !== 4'b0101 || a_odata !== 32'h0002_005A) begin n_bad++; $display("FAIL ind_after2 got ovalid=%b odata=%h exp 0101/0002005a", a_ovalid, a_odata); end
    a_sel = 2'd3; a_data = 8'h03;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL ind_ready3 got %b exp 1", a_ready); end
    step();
    a_valid = 1'b0;
    n_cmp++; if (a_ovalid !== 4'b1001 || a_odata !== 32'h0300_005A) begin n_bad++; $display("FAIL ind_after3 got ovalid=%b odata=%h exp 1001/0300005a", a_ovalid, a_odata); end
    step();
    n_cmp++; if (a_ovalid !== 4'b0001 || a_odata !== 32'h0000_005A) begin n_bad++; $display("FAIL ind_ch0_kept got ovalid=%b odata=%h exp 0001/0000005a", a_ovalid, a_odata); end
    a_ordy = 4'b1111;
    step();
    n_cmp++; if (a_ovalid !== 4'b0000) begin n_bad++; $display("FAIL ind_drain got %b exp 0000", a_ovalid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    vals[0] = 8'hC1; vals[1] = 8'hC2; vals[2] = 8'hC3;
    a_ordy = 4'b1111; a_sel = 2'd3; a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_data = vals[i];
      step();
      n_cmp++; if (a_ovalid !== 4'b1000 || a_odata !== {vals[i], 24'h0}) begin n_bad++; $display("FAIL b2b_%0d got ovalid=%b odata=%h exp 1000/%h000000", i, a_ovalid, a_odata, vals[i]); end
    end
    a_valid = 1'b0;
    step();
  endtask

  task automatic test_err();
    b_sel = 2'd3; b_data = 8'hEE; b_valid = 1'b1;
    #1;
    n_cmp++; if (b_ready !== 1'b1 || b_err !== 1'b0) begin n_bad++; $display("FAIL err_pre got ready=%b err=%b exp 1/0", b_ready, b_err); end
    step();
    n_cmp++; if (b_err !== 1'b1 || b_ovalid !== 3'b000) begin n_bad++; $display("FAIL err_first got err=%b ovalid=%b exp 1/000", b_err, b_ovalid); end
    step();
    b_valid = 1'b0;
    n_cmp++; if (b_err !== 1'b1 || b_ovalid !== 3'b000) begin n_bad++; $display("FAIL err_b2b got err=%b ovalid=%b exp 1/000", b_err, b_ovalid); end
    step();
    n_cmp++; if (b_err !== 1'b0 || b_ovalid !== 3'b000) begin n_bad++; $display("FAIL err_clear got err=%b ovalid=%b exp 0/000", b_err, b_ovalid); end
    b_sel = 2'd2; b_data = 8'h3C; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    n_cmp++; if (b_err !== 1'b0 || b_ovalid !== 3'b100 || b_odata !== 24'h3C_0000) begin n_bad++; $display("FAIL err_inrange got err=%b ovalid=%b odata=%h exp 0/100/3c0000", b_err, b_ovalid, b_odata); end
    step();
  endtask

  task automatic test_reset_mid();
    a_ordy = 4'b0000; a_sel = 2'd0; a_data = 8'h77; a_valid = 1'b1;
    step();
    a_sel = 2'd3; a_data = 8'h88;
    step();
    a_valid = 1'b0;
    n_cmp++; if (a_ovalid !== 4'b1001) begin n_bad++; $display("FAIL rm_full got %b exp 1001", a_ovalid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (a_ovalid !== 4'b0000 || a_odata !== 32'h0) begin n_bad++; $display("FAIL rm_async got ovalid=%b odata=%h exp 0000/0", a_ovalid, a_odata); end
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready got %b exp 1", a_ready); end
    a_ordy = 4'b1111;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (a_ovalid !== 4'b0000 || a_err !== 1'b0) begin n_bad++; $display("FAIL rm_post_%0d got ovalid=%b err=%b exp 0000/0", i, a_ovalid, a_err); end
    end
  endtask

`ifdef DEMUX_STREAM_CNT_EN
  task automatic test_cnt();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (a_cnt !== 64'h0) begin n_bad++; $display("FAIL cnt_rst got %h exp 0", a_cnt); end
    step();
    rst_n = 1'b1;
    step();
    a_ordy = 4'b1111; a_sel = 2'd0; a_data = 8'h42; a_valid = 1'b1;
    repeat (65537) step();
    a_valid = 1'b0;
    step();
    step();
    n_cmp++; if (a_cnt !== 64'h0000_0000_0000_0001) begin n_bad++; $display("FAIL cnt_wrap got %h exp 0000000000000001", a_cnt); end
    n_cmp++; if (b_cnt !== 48'h0) begin n_bad++; $display("FAIL cnt_dut3 got %h exp 0", b_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_independent();
    test_back_to_back();
    test_err();
    test_reset_mid();
`ifdef DEMUX_STREAM_CNT_EN
    test_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
